// File: rtl/uart_cmd_decode.sv
// -----------------------------------------------------------------------------
// uart_cmd_decode
//
// Byte-level command decoder placed behind the UART receiver. Each received
// byte (rx_data qualified by the one-cycle po_flag strobe) is interpreted:
//   - WR_CMD opens a write frame. The next WR_LEN bytes are pushed into the
//     SDRAM write FIFO, and then wr_trig pulses.
//   - RD_CMD outside a frame pulses rd_trig.
//   - Any other byte outside a frame is ignored.
// A write frame that stalls for TIMEOUT clocks between bytes is abandoned,
// and frame_err pulses.
//
// Ports
//   sclk           in   system clock
//   s_rst_n        in   asynchronous active-low reset
//   rx_data[7:0]   in   received byte, valid with po_flag
//   po_flag        in   one-cycle byte-valid strobe
//   wfifo_wr_en    out  write-FIFO push strobe, one cycle per payload byte
//   wfifo_wr_data  out  payload byte; holds the last pushed value
//   wr_trig        out  one-cycle pulse: a full write frame was delivered
//   rd_trig        out  one-cycle pulse: a read command was received
//   frame_err      out  one-cycle pulse: a write frame was aborted by timeout
//
// All outputs are registered.
// -----------------------------------------------------------------------------
module uart_cmd_decode #(
    parameter logic [7:0]  WR_CMD  = 8'h55,
    parameter logic [7:0]  RD_CMD  = 8'hAA,
    parameter int unsigned WR_LEN  = 4,      // 1..255
    parameter int unsigned TIMEOUT = 52080   // 1..65535
) (
    input  logic       sclk,
    input  logic       s_rst_n,
    input  logic [7:0] rx_data,
    input  logic       po_flag,
    output logic       wfifo_wr_en,
    output logic [7:0] wfifo_wr_data,
    output logic       wr_trig,
    output logic       rd_trig,
    output logic       frame_err
);

    localparam logic [7:0]  LAST_IDX = 8'(WR_LEN - 1);
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        WR_DATA = 1'b1
    } state_t;

    state_t      state, state_nxt;
    logic [7:0]  byte_cnt, byte_cnt_nxt;
    logic [15:0] tmo_cnt, tmo_cnt_nxt;

    // wr_pend marks the final payload byte. It is delayed by one more register
    // so that wr_trig follows the last FIFO push by exactly one cycle.
    logic        wr_pend, wr_pend_nxt;

    logic        wr_en_nxt;
    logic [7:0]  wr_data_nxt;
    logic        rd_trig_nxt;
    logic        frame_err_nxt;

    // -------------------------------------------------------------------------
    // Next-state and next-output logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the case statement. A path
        // that leaves a signal unassigned would infer a latch.
        state_nxt     = state;
        byte_cnt_nxt  = byte_cnt;
        tmo_cnt_nxt   = tmo_cnt;
        wr_pend_nxt   = 1'b0;
        wr_en_nxt     = 1'b0;
        wr_data_nxt   = wfifo_wr_data;   // hold the last pushed byte
        rd_trig_nxt   = 1'b0;
        frame_err_nxt = 1'b0;

        case (state)
            IDLE: begin
                tmo_cnt_nxt = '0;
                if (po_flag) begin
                    if (rx_data == WR_CMD) begin
                        state_nxt    = WR_DATA;
                        byte_cnt_nxt = '0;
                    end else if (rx_data == RD_CMD) begin
                        rd_trig_nxt = 1'b1;
                    end
                end
            end

            WR_DATA: begin
                if (po_flag) begin
                    // Inside a frame, every byte is payload, command values
                    // included. A byte that arrives on the expiry cycle takes
                    // priority over the timeout.
                    wr_en_nxt    = 1'b1;
                    wr_data_nxt  = rx_data;
                    byte_cnt_nxt = byte_cnt + 8'd1;
                    tmo_cnt_nxt  = '0;
                    if (byte_cnt == LAST_IDX) begin
                        state_nxt   = IDLE;
                        wr_pend_nxt = 1'b1;
                    end
                end else if (tmo_cnt == TMO_LAST) begin
                    // Abandon the frame. Bytes already pushed stay in the FIFO.
                    state_nxt     = IDLE;
                    tmo_cnt_nxt   = '0;
                    frame_err_nxt = 1'b1;
                end else begin
                    tmo_cnt_nxt = tmo_cnt + 16'd1;
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    // NOTE: an asynchronous reset clears everything at once. That includes
    // wr_pend, so a wr_trig still in flight is dropped.
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state         <= IDLE;
            byte_cnt      <= '0;
            tmo_cnt       <= '0;
            wr_pend       <= 1'b0;
            wfifo_wr_en   <= 1'b0;
            wfifo_wr_data <= 8'h00;
            wr_trig       <= 1'b0;
            rd_trig       <= 1'b0;
            frame_err     <= 1'b0;
        end else begin
            // NOTE: use non-blocking assignments so that every register samples
            // pre-edge values. Blocking assignments here would let one
            // register's new value leak into the next register's input.
            state         <= state_nxt;
            byte_cnt      <= byte_cnt_nxt;
            tmo_cnt       <= tmo_cnt_nxt;
            wr_pend       <= wr_pend_nxt;
            wfifo_wr_en   <= wr_en_nxt;
            wfifo_wr_data <= wr_data_nxt;
            wr_trig       <= wr_pend;
            rd_trig       <= rd_trig_nxt;
            frame_err     <= frame_err_nxt;
        end
    end

endmodule

// File: tb/tb_uart_cmd_decode.sv
// -----------------------------------------------------------------------------
// tb_uart_cmd_decode
//
// Directed bench for uart_cmd_decode with WR_LEN=4 and TIMEOUT=100.
//
// The main sequence drives bytes. After each byte it pushes the output event
// it expects onto a scoreboard, tagged with the clock index. A negedge monitor
// pops one entry for every cycle in which any output is high, and compares the
// cycle and all outputs against that entry. An output with no matching entry
// is an error. So is an entry left over at the end.
//
// Timing reference: cyc counts rising edges. A byte sampled at edge e produces
// rd_trig/wfifo_wr_en visible at monitor cycle e, wr_trig at e+1, and
// frame_err at (last payload edge)+TIMEOUT.
// -----------------------------------------------------------------------------
module tb_uart_cmd_decode;

    localparam int unsigned WR_LEN  = 4;
    localparam int unsigned TIMEOUT = 100;

    logic       sclk;
    logic       s_rst_n;
    logic [7:0] rx_data;
    logic       po_flag;
    logic       wfifo_wr_en;
    logic [7:0] wfifo_wr_data;
    logic       wr_trig;
    logic       rd_trig;
    logic       frame_err;

    uart_cmd_decode #(
        .WR_CMD  (8'h55),
        .RD_CMD  (8'hAA),
        .WR_LEN  (WR_LEN),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .sclk          (sclk),
        .s_rst_n       (s_rst_n),
        .rx_data       (rx_data),
        .po_flag       (po_flag),
        .wfifo_wr_en   (wfifo_wr_en),
        .wfifo_wr_data (wfifo_wr_data),
        .wr_trig       (wr_trig),
        .rd_trig       (rd_trig),
        .frame_err     (frame_err)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    int cyc = 0;
    always @(posedge sclk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------------------------------------------------------- scoreboard
    typedef struct {
        int         cyc;
        logic       wr_en;
        logic [7:0] data;
        logic       wr_trig;
        logic       rd_trig;
        logic       frame_err;
    } ev_t;

    ev_t sb[$];
    ev_t mon_ev;

    task automatic exp_event(input int c, input logic we, input logic [7:0] d,
                             input logic wt, input logic rt, input logic fe);
        ev_t e;
        e.cyc = c; e.wr_en = we; e.data = d;
        e.wr_trig = wt; e.rd_trig = rt; e.frame_err = fe;
        sb.push_back(e);
    endtask

    always @(negedge sclk) begin
        if (wfifo_wr_en || wr_trig || rd_trig || frame_err) begin
            if (sb.size() == 0) begin
                check("unexpected_output", {28'd0, wfifo_wr_en, wr_trig, rd_trig, frame_err}, 32'd0);
            end else begin
                mon_ev = sb.pop_front();
                check("event_cycle", cyc, mon_ev.cyc);
                check("wfifo_wr_en", {31'd0, wfifo_wr_en}, {31'd0, mon_ev.wr_en});
                check("wr_trig",     {31'd0, wr_trig},     {31'd0, mon_ev.wr_trig});
                check("rd_trig",     {31'd0, rd_trig},     {31'd0, mon_ev.rd_trig});
                check("frame_err",   {31'd0, frame_err},   {31'd0, mon_ev.frame_err});
                if (mon_ev.wr_en)
                    check("wfifo_wr_data", {24'd0, wfifo_wr_data}, {24'd0, mon_ev.data});
            end
        end
    end

    // ---------------------------------------------------------------- stimulus
    // The main sequence always resumes 1 time unit after a rising edge.
    int last_edge = 0;

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge sclk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        po_flag = 1'b1;
        rx_data = b;
        @(posedge sclk);
        #1;
        po_flag   = 1'b0;
        last_edge = cyc;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wr_en"},   {31'd0, wfifo_wr_en},   32'd0);
        check({tag, "_wr_data"}, {24'd0, wfifo_wr_data}, 32'd0);
        check({tag, "_wr_trig"}, {31'd0, wr_trig},       32'd0);
        check({tag, "_rd_trig"}, {31'd0, rd_trig},       32'd0);
        check({tag, "_frm_err"}, {31'd0, frame_err},     32'd0);
    endtask

    logic [7:0] pay_a [4];
    logic [7:0] pay_b [4];

    initial begin
        pay_a = '{8'h11, 8'h22, 8'h33, 8'h44};
        pay_b = '{8'hAA, 8'h55, 8'h00, 8'hFF};

        s_rst_n = 1'b0;
        po_flag = 1'b0;
        rx_data = 8'h00;
        idle(3);
        check_all_zero("reset");
        s_rst_n = 1'b1;
        idle(2);

        // Read command, twice: the second AA proves the FSM stayed in IDLE.
        send(8'hAA); exp_event(last_edge, 0, 8'h00, 0, 1, 0);
        idle(3);
        send(8'hAA); exp_event(last_edge, 0, 8'h00, 0, 1, 0);
        idle(3);

        // Write frame with 90-clock gaps. The total exceeds TIMEOUT, so each
        // byte must restart the timeout count.
        send(8'h55);
        for (int i = 0; i < 4; i++) begin
            idle(90);
            send(pay_a[i]);
            exp_event(last_edge, 1, pay_a[i], 0, 0, 0);
        end
        exp_event(last_edge + 1, 0, 8'h00, 1, 0, 0);
        idle(5);
        check("wr_data_hold", {24'd0, wfifo_wr_data}, 32'h44);

        // Back-to-back payload bytes that carry command values.
        send(8'h55);
        for (int i = 0; i < 4; i++) begin
            send(pay_b[i]);
            exp_event(last_edge, 1, pay_b[i], 0, 0, 0);
        end
        exp_event(last_edge + 1, 0, 8'h00, 1, 0, 0);
        // A read command sampled in the cycle where wr_trig is high.
        idle(1);
        send(8'hAA); exp_event(last_edge, 0, 8'h00, 0, 1, 0);
        idle(3);

        // Timeout: frame_err fires exactly TIMEOUT cycles after the last byte.
        send(8'h55);
        idle(10);
        send(8'h01); exp_event(last_edge, 1, 8'h01, 0, 0, 0);
        idle(10);
        send(8'h02); exp_event(last_edge, 1, 8'h02, 0, 0, 0);
        exp_event(last_edge + TIMEOUT, 0, 8'h00, 0, 0, 1);
        idle(TIMEOUT + 10);
        send(8'hAA); exp_event(last_edge, 0, 8'h00, 0, 1, 0);
        idle(3);

        // Boundary: bytes sampled on the cycle in which the counter holds TIMEOUT-1.
        send(8'h55);
        idle(5);
        send(8'h01); exp_event(last_edge, 1, 8'h01, 0, 0, 0);
        idle(TIMEOUT - 1);
        send(8'h02); exp_event(last_edge, 1, 8'h02, 0, 0, 0);
        idle(TIMEOUT - 1);
        send(8'h03); exp_event(last_edge, 1, 8'h03, 0, 0, 0);
        send(8'h04); exp_event(last_edge, 1, 8'h04, 0, 0, 0);
        exp_event(last_edge + 1, 0, 8'h00, 1, 0, 0);
        idle(5);

        // Garbage in IDLE produces no output.
        send(8'h00);
        idle(2);
        send(8'h7F);
        send(8'hFE);
        idle(5);

        // Reset mid-frame while a push is on the outputs.
        send(8'h55);
        idle(3);
        send(8'h01);
        check("pre_reset_wr_en", {31'd0, wfifo_wr_en}, 32'd1);
        #1 s_rst_n = 1'b0;
        #1 check_all_zero("mid_rst");
        idle(2);
        s_rst_n = 1'b1;
        idle(2);
        send(8'hAA); exp_event(last_edge, 0, 8'h00, 0, 1, 0);
        idle(3);

        // Reset with wr_trig pending: the trigger must never appear.
        send(8'h55);
        for (int i = 0; i < 3; i++) begin
            send(pay_a[i]);
            exp_event(last_edge, 1, pay_a[i], 0, 0, 0);
        end
        send(pay_a[3]);
        #1 s_rst_n = 1'b0;
        #1 check_all_zero("pend_rst");
        idle(2);
        s_rst_n = 1'b1;
        idle(6);

        check("scoreboard_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
